// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: voting-session sequencer for the three-switch voting machine.
// Opens a ballot window, latches one ballot per cast with a lockout between
// voters, keeps saturating per-candidate tallies, picks a winner on close and
// rotates the tallies onto a single BCD digit for the display path.
// Optional build macro: VOTE_INVALID_CNT_EN adds the cnt_inv port. When it is
// defined, invalid ballots are also counted and shown as the fourth display slot.
module vote_session_ctrl #(
  parameter int CW         = 4,
  parameter int MAX_COUNT  = 9,
  parameter int LOCK_TICKS = 2500,
  parameter int DISP_TICKS = 5000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          close,
  input  logic          cast,
  input  logic [2:0]    sel,
  output logic [2:0]    state,
  output logic          lockout,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b,
  output logic [CW-1:0] cnt_c,
`ifdef VOTE_INVALID_CNT_EN
  output logic [CW-1:0] cnt_inv,
`endif
  output logic [1:0]    winner,
  output logic [1:0]    disp_idx,
  output logic [3:0]    disp_bcd
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OPEN  = 3'd1;
  localparam logic [2:0] S_LOCK  = 3'd2;
  localparam logic [2:0] S_TALLY = 3'd3;
  localparam logic [2:0] S_SHOW  = 3'd4;

  // One timer is shared by LOCK and SHOW because the two states never overlap.
  localparam int TMAX = (LOCK_TICKS > DISP_TICKS) ? LOCK_TICKS : DISP_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TICKS - 1);
  localparam logic [TW-1:0] DISP_LAST = TW'(DISP_TICKS - 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_COUNT);

`ifdef VOTE_INVALID_CNT_EN
  localparam logic [1:0] IDX_LAST = 2'd3;
`else
  localparam logic [1:0] IDX_LAST = 2'd2;
`endif

  logic [2:0]    state_q,    state_d;
  logic          lockout_q,  lockout_d;
  logic [CW-1:0] cnt_a_q,    cnt_a_d;
  logic [CW-1:0] cnt_b_q,    cnt_b_d;
  logic [CW-1:0] cnt_c_q,    cnt_c_d;
  logic [1:0]    winner_q,   winner_d;
  logic [1:0]    disp_idx_q, disp_idx_d;
  logic [3:0]    disp_bcd_q, disp_bcd_d;
  logic [TW-1:0] timer_q,    timer_d;
  logic          clear_session;
`ifdef VOTE_INVALID_CNT_EN
  logic [CW-1:0] cnt_inv_q,  cnt_inv_d;
`endif

  // A ballot that arrives at saturation is accepted, but it is not counted.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= MAX_CNT) ? v : v + CW'(1);
  endfunction

  // Next-state, tally, timer and display computation.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so that no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    cnt_a_d       = cnt_a_q;
    cnt_b_d       = cnt_b_q;
    cnt_c_d       = cnt_c_q;
    winner_d      = winner_q;
    disp_idx_d    = disp_idx_q;
    timer_d       = timer_q;
    clear_session = 1'b0;
`ifdef VOTE_INVALID_CNT_EN
    cnt_inv_d     = cnt_inv_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear_session = 1'b1;
          state_d       = S_OPEN;
        end
      end
      S_OPEN: begin
        if (cast) begin
          case (sel)
            3'b100:  cnt_a_d = sat_inc(cnt_a_q);
            3'b010:  cnt_b_d = sat_inc(cnt_b_q);
            3'b001:  cnt_c_d = sat_inc(cnt_c_q);
`ifdef VOTE_INVALID_CNT_EN
            default: cnt_inv_d = sat_inc(cnt_inv_q);
`else
            default: ;
`endif
          endcase
          state_d = S_LOCK;
          timer_d = '0;
        end
        // A close in the same cycle as a cast still counts the ballot, and the close takes priority over the lockout.
        if (close) state_d = S_TALLY;
      end
      S_LOCK: begin
        if (close) begin
          state_d = S_TALLY;
        end else if (tick) begin
          if (timer_q == LOCK_LAST) state_d = S_OPEN;
          else                      timer_d = timer_q + TW'(1);
        end
      end
      S_TALLY: begin
        if      (cnt_a_q > cnt_b_q && cnt_a_q > cnt_c_q) winner_d = 2'd1;
        else if (cnt_b_q > cnt_a_q && cnt_b_q > cnt_c_q) winner_d = 2'd2;
        else if (cnt_c_q > cnt_a_q && cnt_c_q > cnt_b_q) winner_d = 2'd3;
        else                                             winner_d = 2'd0;
        state_d    = S_SHOW;
        disp_idx_d = 2'd0;
        timer_d    = '0;
      end
      S_SHOW: begin
        if (start) begin
          clear_session = 1'b1;
          state_d       = S_OPEN;
        end else if (tick) begin
          if (timer_q == DISP_LAST) begin
            timer_d    = '0;
            disp_idx_d = (disp_idx_q == IDX_LAST) ? 2'd0 : disp_idx_q + 2'd1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_session) begin
      cnt_a_d    = '0;
      cnt_b_d    = '0;
      cnt_c_d    = '0;
      winner_d   = 2'd0;
      disp_idx_d = 2'd0;
`ifdef VOTE_INVALID_CNT_EN
      cnt_inv_d  = '0;
`endif
    end

    lockout_d = (state_d == S_LOCK);

    // The display digit follows the registered index, so it lags an index change by one cycle.
    case (disp_idx_q)
      2'd0:    disp_bcd_d = 4'(cnt_a_q);
      2'd1:    disp_bcd_d = 4'(cnt_b_q);
      2'd2:    disp_bcd_d = 4'(cnt_c_q);
`ifdef VOTE_INVALID_CNT_EN
      default: disp_bcd_d = 4'(cnt_inv_q);
`else
      default: disp_bcd_d = 4'd0;
`endif
    endcase
  end

  // State registers with a synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so that every flop samples values from before the edge.
    if (rst) begin
      state_q    <= S_IDLE;
      lockout_q  <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      cnt_c_q    <= '0;
      winner_q   <= 2'd0;
      disp_idx_q <= 2'd0;
      disp_bcd_q <= 4'd0;
      timer_q    <= '0;
`ifdef VOTE_INVALID_CNT_EN
      cnt_inv_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lockout_q  <= lockout_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      cnt_c_q    <= cnt_c_d;
      winner_q   <= winner_d;
      disp_idx_q <= disp_idx_d;
      disp_bcd_q <= disp_bcd_d;
      timer_q    <= timer_d;
`ifdef VOTE_INVALID_CNT_EN
      cnt_inv_q  <= cnt_inv_d;
`endif
    end
  end

  assign state    = state_q;
  assign lockout  = lockout_q;
  assign cnt_a    = cnt_a_q;
  assign cnt_b    = cnt_b_q;
  assign cnt_c    = cnt_c_q;
  assign winner   = winner_q;
  assign disp_idx = disp_idx_q;
  assign disp_bcd = disp_bcd_q;
`ifdef VOTE_INVALID_CNT_EN
  assign cnt_inv  = cnt_inv_q;
`endif

endmodule
